// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM-to-memory image loader: FSM encoding and the
// big-endian lane-to-bit mapping used to assemble words from ROM bytes.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWrite,
        StDone
    } state_e;

    // Byte lane n of a word occupies bits [LaneNLsb +: 8]; lane 0 is the MSB.
    localparam int unsigned Lane0Lsb = 24;
    localparam int unsigned Lane1Lsb = 16;
    localparam int unsigned Lane2Lsb = 8;
    localparam int unsigned Lane3Lsb = 0;

    localparam logic [1:0] LastLane = 2'd3;

    function automatic logic [31:0] insert_byte(input logic [31:0] value,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] w_word;
        w_word = value;
        unique case (lane)
            2'd0:    w_word[Lane0Lsb +: 8] = data;
            2'd1:    w_word[Lane1Lsb +: 8] = data;
            2'd2:    w_word[Lane2Lsb +: 8] = data;
            default: w_word[Lane3Lsb +: 8] = data;
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/rom_loader.sv
// Copies a byte-wide ROM image into word-wide memory as big-endian words, holding
// the CPU in reset until the last word has been acknowledged.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'd0,
    parameter logic [31:0] MAX_BYTES    = 32'd65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write_req,
    input  logic        mem_write_ack,
    output logic        cpu_reset,
    output logic        busy,
    output logic        finished,
    output logic [31:0] word_count
);

    state_e      r_state;
    logic [31:0] r_rom_address;
    logic [31:0] r_mem_address;
    logic [31:0] r_buffer;
    logic        r_write_req;
    logic [31:0] r_word_count;
    logic        r_last;
    logic        r_busy;
    logic        r_finished;
    logic        r_cpu_reset;

    logic [1:0]  w_lane;
    logic        w_last_byte;

    assign w_lane      = r_rom_address[1:0];
    // The runaway guard ends the image exactly like rom_done would.
    assign w_last_byte = rom_done || (r_rom_address == MAX_BYTES - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_rom_address <= 32'd0;
            r_mem_address <= BASE_ADDRESS;
            r_buffer      <= 32'd0;
            r_write_req   <= 1'b0;
            r_word_count  <= 32'd0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
            r_finished    <= 1'b0;
            r_cpu_reset   <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state       <= StFetch;
                        r_rom_address <= 32'd0;
                        r_mem_address <= BASE_ADDRESS;
                        r_buffer      <= 32'd0;
                        r_word_count  <= 32'd0;
                        r_last        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_finished    <= 1'b0;
                        r_cpu_reset   <= 1'b1;
                    end
                end
                StFetch: begin
                    r_buffer      <= insert_byte(r_buffer, w_lane, rom_byte);
                    r_rom_address <= r_rom_address + 32'd1;
                    if (w_lane == LastLane || w_last_byte) begin
                        r_state     <= StWrite;
                        r_write_req <= 1'b1;
                        r_last      <= w_last_byte;
                    end
                end
                StWrite: begin
                    if (mem_write_ack) begin
                        r_write_req   <= 1'b0;
                        r_word_count  <= r_word_count + 32'd1;
                        r_mem_address <= r_mem_address + 32'd1;
                        r_buffer      <= 32'd0;
                        if (r_last) begin
                            r_state     <= StDone;
                            r_busy      <= 1'b0;
                            r_finished  <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= StFetch;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rom_address   = r_rom_address;
    assign mem_address   = r_mem_address;
    assign mem_data      = r_buffer;
    assign mem_write_req = r_write_req;
    assign word_count    = r_word_count;
    assign busy          = r_busy;
    assign finished      = r_finished;
    assign cpu_reset     = r_cpu_reset;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed ROM images, expected writes queued at
// stimulus time and checked by independent monitors on each write handshake.
module tb_rom_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        ack_a;
    logic        done_en;
    logic [31:0] done_idx;
    logic [7:0]  rom [512];
    logic [7:0]  rom_b [8];

    logic [31:0] rom_addr_a, mem_addr_a, mem_data_a, wc_a;
    logic        req_a, cpu_rst_a, busy_a, fin_a;
    logic [7:0]  rom_byte_a;
    logic        rom_done_a;

    logic [31:0] rom_addr_b, mem_addr_b, mem_data_b, wc_b;
    logic        req_b, cpu_rst_b, busy_b, fin_b;
    logic [7:0]  rom_byte_b;

    assign rom_byte_a = (rom_addr_a < 32'd512) ? rom[rom_addr_a[8:0]] : 8'h00;
    assign rom_done_a = done_en && (rom_addr_a == done_idx);
    assign rom_byte_b = (rom_addr_b < 32'd8) ? rom_b[rom_addr_b[2:0]] : 8'h99;

    rom_loader u_dut_a (
        .clk           (clk),
        .reset         (rst),
        .start         (start_a),
        .rom_address   (rom_addr_a),
        .rom_byte      (rom_byte_a),
        .rom_done      (rom_done_a),
        .mem_address   (mem_addr_a),
        .mem_data      (mem_data_a),
        .mem_write_req (req_a),
        .mem_write_ack (ack_a),
        .cpu_reset     (cpu_rst_a),
        .busy          (busy_a),
        .finished      (fin_a),
        .word_count    (wc_a)
    );

    rom_loader #(
        .BASE_ADDRESS (32'h0000_0100),
        .MAX_BYTES    (32'd8)
    ) u_dut_b (
        .clk           (clk),
        .reset         (rst),
        .start         (start_b),
        .rom_address   (rom_addr_b),
        .rom_byte      (rom_byte_b),
        .rom_done      (1'b0),
        .mem_address   (mem_addr_b),
        .mem_data      (mem_data_b),
        .mem_write_req (req_b),
        .mem_write_ack (1'b1),
        .cpu_reset     (cpu_rst_b),
        .busy          (busy_b),
        .finished      (fin_b),
        .word_count    (wc_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    wr_t         q_a[$];
    wr_t         q_b[$];
    int          hs_a = 0;
    int          hs_b = 0;
    logic [31:0] cap_a [512];
    int          exp_req_len = 1;
    logic        ack_always = 1'b1;
    int          ack_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int base);
        return {rom[base], rom[base + 1], rom[base + 2], rom[base + 3]};
    endfunction

    // Memory-side responder for instance A: tied-high or delayed acknowledge.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        ack_a = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_always) ack_a = 1'b1;
            else if (req_a && wait_cnt >= ack_delay) ack_a = 1'b1;
            else ack_a = 1'b0;
            if (req_a && !ack_a) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    // Monitor A: handshakes against the queue, request stability and length.
    initial begin
        int          req_len;
        logic        held_v;
        logic [31:0] held_addr;
        logic [31:0] held_data;
        wr_t         e;
        req_len = 0;
        held_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v  = 1'b0;
                req_len = 0;
            end else begin
                if (req_a) begin
                    if (held_v) begin
                        check("a_addr_stable", mem_addr_a, held_addr);
                        check("a_data_stable", mem_data_a, held_data);
                    end
                    req_len++;
                    if (ack_a) begin
                        if (q_a.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL a_unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                                     mem_addr_a, mem_data_a);
                        end else begin
                            e = q_a.pop_front();
                            check("a_write_addr", mem_addr_a, e.addr);
                            check("a_write_data", mem_data_a, e.data);
                        end
                        if (exp_req_len != 0) check("a_req_len", 32'(req_len), 32'(exp_req_len));
                        if (hs_a < 512) cap_a[hs_a] = mem_data_a;
                        hs_a++;
                        req_len = 0;
                        held_v  = 1'b0;
                    end else begin
                        held_v    = 1'b1;
                        held_addr = mem_addr_a;
                        held_data = mem_data_a;
                    end
                end else begin
                    req_len = 0;
                    held_v  = 1'b0;
                end
                check("a_cpu_reset_vs_done", 32'(cpu_rst_a), 32'(!fin_a));
            end
        end
    end

    // Monitor B: acknowledge is tied high, so every request cycle is a write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && req_b) begin
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL b_unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                             mem_addr_b, mem_data_b);
                end else begin
                    e = q_b.pop_front();
                    check("b_write_addr", mem_addr_b, e.addr);
                    check("b_write_data", mem_data_b, e.data);
                end
                hs_b++;
            end
        end
    end

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_finished_a(input string name, input int budget);
        int n;
        n = 0;
        while (!fin_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!fin_a) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got finished=0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic end_checks_a(input string name, input int exp_words);
        check({name, "_finished"}, 32'(fin_a), 32'd1);
        check({name, "_busy"}, 32'(busy_a), 32'd0);
        check({name, "_cpu_reset"}, 32'(cpu_rst_a), 32'd0);
        check({name, "_word_count"}, wc_a, 32'(exp_words));
        check({name, "_writes_seen"}, 32'(hs_a), 32'(exp_words));
        check({name, "_queue_empty"}, 32'(q_a.size()), 32'd0);
    endtask

    task automatic load_case1();
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        rom[7]   = 8'h01;
        done_idx = 32'd7;
        done_en  = 1'b1;
        q_a.push_back('{addr: 32'd0, data: 32'h0000_0000});
        q_a.push_back('{addr: 32'd1, data: 32'h0000_0001});
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        done_en  = 1'b0;
        done_idx = 32'd0;
        for (int i = 0; i < 512; i++) rom[i] = 8'h00;
        for (int i = 0; i < 8; i++) rom_b[i] = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_rom_address", rom_addr_a, 32'd0);
        check("rst_mem_address", mem_addr_a, 32'd0);
        check("rst_mem_data", mem_data_a, 32'd0);
        check("rst_req", 32'(req_a), 32'd0);
        check("rst_word_count", wc_a, 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_finished", 32'(fin_a), 32'd0);
        check("rst_cpu_reset", 32'(cpu_rst_a), 32'd1);
        check("rst_b_mem_address", mem_addr_b, 32'h0000_0100);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cpu_reset", 32'(cpu_rst_a), 32'd1);

        // Case 1: two words, ack tied high (also high outside WRITE).
        hs_a = 0;
        exp_req_len = 1;
        load_case1();
        pulse_start_a();
        check("c1_busy_after_start", 32'(busy_a), 32'd1);
        wait_finished_a("c1", 200);
        end_checks_a("c1", 2);

        // Case 2: 292-byte image, 73 words; a stray start mid-load is ignored.
        hs_a = 0;
        for (int i = 0; i < 292; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[12] = 8'h0E;
        rom[13] = 8'h14;
        rom[14] = 8'h00;
        rom[15] = 8'h00;
        for (int i = 288; i < 292; i++) rom[i] = 8'h00;
        done_idx = 32'd291;
        for (int w = 0; w < 73; w++) q_a.push_back('{addr: 32'(w), data: word_at(4 * w)});
        pulse_start_a();
        repeat (50) @(negedge clk);
        pulse_start_a();
        wait_finished_a("c2", 2000);
        end_checks_a("c2", 73);
        check("c2_word3", cap_a[3], 32'h0E14_0000);
        check("c2_word72", cap_a[72], 32'h0000_0000);

        // Case 3: 6-byte image, partial last word zero-padded; restart from DONE.
        hs_a = 0;
        rom[0] = 8'hAA;
        rom[1] = 8'hBB;
        rom[2] = 8'hCC;
        rom[3] = 8'hDD;
        rom[4] = 8'hEE;
        rom[5] = 8'hFF;
        rom[6] = 8'h12;
        rom[7] = 8'h34;
        done_idx = 32'd5;
        q_a.push_back('{addr: 32'd0, data: 32'hAABB_CCDD});
        q_a.push_back('{addr: 32'd1, data: 32'hEEFF_0000});
        pulse_start_a();
        wait_finished_a("c3", 200);
        end_checks_a("c3", 2);

        // Case 4: ack delayed 3 cycles -> request held for 4 cycles per word.
        hs_a = 0;
        ack_always  = 1'b0;
        ack_delay   = 3;
        exp_req_len = 4;
        q_a.push_back('{addr: 32'd0, data: 32'hAABB_CCDD});
        q_a.push_back('{addr: 32'd1, data: 32'hEEFF_0000});
        pulse_start_a();
        wait_finished_a("c4", 200);
        end_checks_a("c4", 2);

        // Case 5: reset during the second WRITE, then a clean reload of case 1.
        hs_a = 0;
        ack_delay   = 0;
        exp_req_len = 0;
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        rom[7]   = 8'h01;
        done_idx = 32'd7;
        q_a.push_back('{addr: 32'd0, data: 32'h0000_0000});
        pulse_start_a();
        n = 0;
        while (hs_a < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c5_first_write_seen", 32'(hs_a), 32'd1);
        ack_delay = 1000;
        n = 0;
        while (!req_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c5_second_req", 32'(req_a), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("c5_rst_rom_address", rom_addr_a, 32'd0);
        check("c5_rst_mem_address", mem_addr_a, 32'd0);
        check("c5_rst_mem_data", mem_data_a, 32'd0);
        check("c5_rst_req", 32'(req_a), 32'd0);
        check("c5_rst_word_count", wc_a, 32'd0);
        check("c5_rst_busy", 32'(busy_a), 32'd0);
        check("c5_rst_finished", 32'(fin_a), 32'd0);
        check("c5_rst_cpu_reset", 32'(cpu_rst_a), 32'd1);
        check("c5_queue_empty", 32'(q_a.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_always  = 1'b1;
        ack_delay   = 0;
        repeat (3) @(negedge clk);
        check("c5_no_req_after_reset", 32'(req_a), 32'd0);
        hs_a = 0;
        exp_req_len = 1;
        load_case1();
        pulse_start_a();
        wait_finished_a("c5", 200);
        end_checks_a("c5", 2);

        // Case 6: rom_done never asserts, MAX_BYTES=8; starts while busy are ignored.
        hs_b = 0;
        for (int i = 0; i < 8; i++) rom_b[i] = 8'(8'h11 * (i + 1));
        q_b.push_back('{addr: 32'h0000_0100, data: 32'h1122_3344});
        q_b.push_back('{addr: 32'h0000_0101, data: 32'h5566_7788});
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!req_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!fin_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("c6_finished", 32'(fin_b), 32'd1);
        check("c6_cpu_reset", 32'(cpu_rst_b), 32'd0);
        check("c6_word_count", wc_b, 32'd2);
        check("c6_writes_seen", 32'(hs_b), 32'd2);
        check("c6_mem_address", mem_addr_b, 32'h0000_0102);
        check("c6_queue_empty", 32'(q_b.size()), 32'd0);
        repeat (10) @(negedge clk);
        check("c6_no_extra_writes", 32'(hs_b), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected finish before 500000");
        $fatal(1, "bench timeout");
    end

endmodule
